phoneme_sequencer: RTL and testbench

//  Queues phoneme codes from the calculator speech front end and plays them in order

---
 rtl/phoneme_pkg.sv | 28 ++
 rtl/phoneme_addr_table.sv | 9 +
 rtl/phoneme_sequencer.sv | 156 +++++++++++++++
 tb/tb_phoneme_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phoneme_pkg.sv
// Shared types for the phoneme sequencer: FSM states, flash range record and the
// code -> flash byte-range table used by the speech front end.
package phoneme_pkg;
  localparam int PHON_CODE_W = 5;
  localparam int PHON_ADDR_W = 24;
  localparam int NUM_CODES   = 2 ** PHON_CODE_W;

  localparam logic [PHON_CODE_W-1:0] PAUSE_CODE = '0;

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_START, S_WAIT, S_GAP, S_DONE
  } seq_state_t;

  typedef struct packed {
    logic [PHON_ADDR_W-1:0] start_addr;
    logic [PHON_ADDR_W-1:0] end_addr;
  } phoneme_range_t;

  // Codes without an entry resolve to {0,0}.
  localparam phoneme_range_t PHONEME_RANGES [NUM_CODES] = '{
    1:       '{start_addr: 24'd403,   end_addr: 24'd411},
    2:       '{start_addr: 24'd2548,  end_addr: 24'd2559},
    3:       '{start_addr: 24'd4096,  end_addr: 24'd4351},
    4:       '{start_addr: 24'd8000,  end_addr: 24'd8799},
    5:       '{start_addr: 24'd12000, end_addr: 24'd12499},
    default: '0
  };
endpackage

// File: rtl/phoneme_addr_table.sv
// Combinational lookup of a phoneme code into its flash byte range.
module phoneme_addr_table
  import phoneme_pkg::*;
(
  input  logic [PHON_CODE_W-1:0] code_i,
  output phoneme_range_t         range_o
);
  assign range_o = PHONEME_RANGES[code_i];
endmodule

// File: rtl/phoneme_sequencer.sv
// Queues phoneme codes and plays them one after another through audio_ctrl,
// with a muted gap after each phoneme and a longer mute for PAUSE tokens.
module phoneme_sequencer
  import phoneme_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int CODE_W       = PHON_CODE_W,
  parameter int ADDR_W       = PHON_ADDR_W,
  parameter int START_HOLD   = 5,
  parameter int GAP_CYCLES   = 1000,
  parameter int PAUSE_CYCLES = 8000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [CODE_W-1:0] push_code,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              busy,
  output logic              done,
  output logic              audio_start,
  output logic [ADDR_W-1:0] audio_start_address,
  output logic [ADDR_W-1:0] audio_end_address,
  output logic              audio_silent,
  input  logic              audio_finish
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int MAX_A = (GAP_CYCLES > PAUSE_CYCLES) ? GAP_CYCLES : PAUSE_CYCLES;
  localparam int MAX_C = (MAX_A > START_HOLD) ? MAX_A : START_HOLD;
  localparam int CNT_W = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(START_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PAUSE_LD = CNT_W'(PAUSE_CYCLES - 1);

  seq_state_t        state_q;
  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]    wr_q, rd_q;
  logic [CODE_W-1:0] code_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] saddr_q, eaddr_q;
  logic              overflow_q, start_q, silent_q, done_q, finish_q;
  logic [CODE_W-1:0] head;
  logic              push_ok, pop, fin_rise;
  phoneme_range_t    range;

  assign full     = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign empty    = (wr_q == rd_q);
  assign push_ok  = push && !full && !flush;
  assign pop      = (state_q == S_POP) && !flush;
  assign head     = mem_q[rd_q[PTR_W-1:0]];
  assign fin_rise = audio_finish && !finish_q;

  assign overflow            = overflow_q;
  assign busy                = (state_q != S_IDLE);
  assign done                = done_q;
  assign audio_start         = start_q;
  assign audio_silent        = silent_q;
  assign audio_start_address = saddr_q;
  assign audio_end_address   = eaddr_q;

  phoneme_addr_table u_table (
    .code_i  (code_q),
    .range_o (range)
  );

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[PTR_W-1:0]] <= push_code;
    if (state_q == S_POP) code_q <= head;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      saddr_q    <= '0;
      eaddr_q    <= '0;
      overflow_q <= 1'b0;
      start_q    <= 1'b0;
      silent_q   <= 1'b0;
      done_q     <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      finish_q <= audio_finish;
      if (flush) begin
        // Abort: drop the queue and go quiet; addresses keep their last value.
        state_q    <= S_IDLE;
        wr_q       <= '0;
        rd_q       <= '0;
        overflow_q <= 1'b0;
        start_q    <= 1'b0;
        silent_q   <= 1'b0;
        done_q     <= 1'b0;
      end else begin
        if (push_ok)       wr_q       <= wr_q + 1'b1;
        if (push && full)  overflow_q <= 1'b1;
        if (pop)           rd_q       <= rd_q + 1'b1;
        done_q <= 1'b0;
        case (state_q)
          S_IDLE:  if (!empty) state_q <= S_POP;
          S_POP: begin
            if (head == PAUSE_CODE) begin
              state_q  <= S_GAP;
              silent_q <= 1'b1;
              cnt_q    <= PAUSE_LD;
            end else begin
              state_q <= S_LOAD;
            end
          end
          S_LOAD: begin
            saddr_q <= range.start_addr;
            eaddr_q <= range.end_addr;
            start_q <= 1'b1;
            cnt_q   <= HOLD_LD;
            state_q <= S_START;
          end
          S_START: begin
            if (cnt_q == '0) begin
              start_q <= 1'b0;
              state_q <= S_WAIT;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          // Only a fresh rising edge counts; a level left high from before is ignored.
          S_WAIT: begin
            if (fin_rise) begin
              state_q  <= S_GAP;
              silent_q <= 1'b1;
              cnt_q    <= GAP_LD;
            end
          end
          S_GAP: begin
            if (cnt_q == '0) begin
              silent_q <= 1'b0;
              if (!empty) begin
                state_q <= S_POP;
              end else begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_phoneme_sequencer.sv
// Randomized bench for phoneme_sequencer with a mock audio_ctrl and an event scoreboard.
module tb_phoneme_sequencer;
  localparam int CW = 5;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0;
  logic          flush = 1'b0;
  logic          audio_finish = 1'b0;
  logic [CW-1:0] push_code = '0;
  logic          full, empty, overflow, busy, done, audio_start, audio_silent;
  logic [AW-1:0] audio_start_address, audio_end_address;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          cyc;
    logic [23:0] s;
    logic [23:0] e;
    int          hold;
    bit          stable;
  } start_rec_t;

  start_rec_t    starts_q[$];
  int            sil_q[$];
  logic [CW-1:0] exp_codes[$];
  start_rec_t    cur;
  int            sil_run, done_cnt, cyc, push_cyc, fin_dly, fin_cnt;
  bit            done_long, prev_start, prev_sil, prev_done, fin_auto;

  phoneme_sequencer dut (
    .clk                 (clk),
    .reset               (reset),
    .push                (push),
    .push_code           (push_code),
    .flush               (flush),
    .full                (full),
    .empty               (empty),
    .overflow            (overflow),
    .busy                (busy),
    .done                (done),
    .audio_start         (audio_start),
    .audio_start_address (audio_start_address),
    .audio_end_address   (audio_end_address),
    .audio_silent        (audio_silent),
    .audio_finish        (audio_finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Flash ranges as the front end defines them; anything else is {0,0}.
  function automatic logic [47:0] ref_range(input logic [CW-1:0] c);
    case (c)
      5'd1:    return {24'd403, 24'd411};
      5'd2:    return {24'd2548, 24'd2559};
      5'd3:    return {24'd4096, 24'd4351};
      5'd4:    return {24'd8000, 24'd8799};
      5'd5:    return {24'd12000, 24'd12499};
      default: return 48'd0;
    endcase
  endfunction

  // One clock: sample at the falling edge, run the mock audio_ctrl, log events.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (fin_auto) begin
      if (audio_start && !prev_start) begin
        audio_finish = 1'b0;
        fin_cnt = fin_dly;
      end else if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) audio_finish = 1'b1;
      end
    end
    if (audio_start) begin
      if (!prev_start) begin
        cur.cyc = cyc; cur.s = audio_start_address; cur.e = audio_end_address;
        cur.hold = 0; cur.stable = 1'b1;
      end
      cur.hold++;
      if (audio_start_address != cur.s || audio_end_address != cur.e) cur.stable = 1'b0;
    end else if (prev_start) begin
      starts_q.push_back(cur);
    end
    if (audio_silent) sil_run++;
    else if (prev_sil) begin
      sil_q.push_back(sil_run);
      sil_run = 0;
    end
    if (done) done_cnt++;
    if (done && prev_done) done_long = 1'b1;
    prev_start = audio_start;
    prev_sil   = audio_silent;
    prev_done  = done;
  endtask

  task automatic clear_mon();
    starts_q.delete();
    sil_q.delete();
    sil_run = 0;
    done_cnt = 0;
    done_long = 1'b0;
  endtask

  task automatic push_codes();
    for (int i = 0; i < exp_codes.size(); i++) begin
      if (i == 0) push_cyc = cyc;
      push = 1'b1;
      push_code = exp_codes[i];
      tick();
    end
    push = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done_in_time"}, 64'(n < budget), 64'd1);
    repeat (3) tick();
  endtask

  // Expected playback: each non-pause code yields one start with its range held
  // for 5 cycles, every code yields one mute run, then a single done.
  task automatic verify_play(input string tag);
    int          ns;
    logic [47:0] rr;
    start_rec_t  r;
    ns = 0;
    for (int i = 0; i < exp_codes.size(); i++) begin
      if (exp_codes[i] != '0) begin
        rr = ref_range(exp_codes[i]);
        if (ns < starts_q.size()) begin
          r = starts_q[ns];
          check($sformatf("%s_p%0d_start_addr", tag, i), 64'(r.s), 64'(rr[47:24]));
          check($sformatf("%s_p%0d_end_addr", tag, i), 64'(r.e), 64'(rr[23:0]));
          check($sformatf("%s_p%0d_hold", tag, i), 64'(r.hold), 64'd5);
          check($sformatf("%s_p%0d_addr_stable", tag, i), 64'(r.stable), 64'd1);
        end
        ns++;
      end
      if (i < sil_q.size())
        check($sformatf("%s_p%0d_silent_len", tag, i), 64'(sil_q[i]),
              (exp_codes[i] == '0) ? 64'd8000 : 64'd1000);
    end
    check({tag, "_num_starts"}, 64'(starts_q.size()), 64'(ns));
    check({tag, "_num_silent"}, 64'(sil_q.size()), 64'(exp_codes.size()));
    check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_1cycle"}, 64'(done_long), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic check_latency(input string tag);
    int lat = -1;
    if (starts_q.size() > 0) lat = starts_q[0].cyc - push_cyc;
    check({tag, "_start_latency"}, 64'(lat), 64'd4);
  endtask

  initial begin
    int  n;
    bit  seen;
    fin_auto = 1'b0;
    fin_cnt = 0;
    cyc = 0;
    clear_mon();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_outputs", 64'({done, audio_start, audio_silent}), 64'd0);
    check("rst_addr", 64'({audio_start_address, audio_end_address}), 64'd0);

    clear_mon();
    fin_auto = 1'b1;
    fin_dly = 20;
    exp_codes = '{5'd1, 5'd2};
    push_codes();
    run_to_done("t1", 5000);
    check_latency("t1");
    verify_play("t1");

    for (int r = 0; r < 3; r++) begin
      clear_mon();
      fin_dly = $urandom_range(40, 8);
      exp_codes.delete();
      n = $urandom_range(4, 1);
      for (int k = 0; k < n; k++) exp_codes.push_back(CW'($urandom_range(7, 1)));
      push_codes();
      run_to_done($sformatf("rnd%0d", r), 6000);
      check_latency($sformatf("rnd%0d", r));
      verify_play($sformatf("rnd%0d", r));
    end

    // Queue fills while the first phoneme waits for a finish that never comes.
    fin_auto = 1'b0;
    audio_finish = 1'b0;
    clear_mon();
    exp_codes = '{5'd3};
    push_codes();
    repeat (12) tick();
    check("t2_busy_in_wait", 64'(busy), 64'd1);
    for (int i = 0; i < 9; i++) begin
      push = 1'b1;
      push_code = CW'($urandom_range(5, 1));
      tick();
      if (i == 7) begin
        check("t2_full_at_8", 64'(full), 64'd1);
        check("t2_no_overflow_at_8", 64'(overflow), 64'd0);
      end
    end
    push = 1'b0;
    check("t2_overflow", 64'(overflow), 64'd1);
    check("t2_full", 64'(full), 64'd1);
    flush = 1'b1;
    push = 1'b1;
    push_code = 5'd1;
    tick();
    flush = 1'b0;
    push = 1'b0;
    check("t2_flush_empty", 64'(empty), 64'd1);
    check("t2_flush_overflow", 64'(overflow), 64'd0);
    check("t2_flush_busy", 64'(busy), 64'd0);
    repeat (20) tick();
    check("t2_flush_push_dropped", 64'({empty, busy}), 64'b10);
    check("t2_no_done", 64'(done_cnt), 64'd0);

    clear_mon();
    fin_auto = 1'b1;
    exp_codes = '{5'd0};
    push_codes();
    run_to_done("t3", 9000);
    verify_play("t3");

    // Finish already high before the start must not end WAIT.
    fin_auto = 1'b0;
    audio_finish = 1'b1;
    clear_mon();
    exp_codes = '{5'd1};
    push_codes();
    repeat (40) tick();
    check("t4_still_waiting", 64'({busy, audio_silent}), 64'b10);
    audio_finish = 1'b0;
    repeat (3) tick();
    check("t4_wait_on_low", 64'({busy, audio_silent}), 64'b10);
    audio_finish = 1'b1;
    tick();
    check("t4_gap_after_rise", 64'(audio_silent), 64'd1);
    run_to_done("t4", 1200);
    verify_play("t4");

    audio_finish = 1'b0;
    clear_mon();
    exp_codes = '{5'd2};
    push_codes();
    repeat (15) tick();
    check("t5_busy_in_wait", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_idle_after_flush", 64'({busy, audio_start, audio_silent, empty}), 64'b0001);
    audio_finish = 1'b1;
    repeat (50) tick();
    check("t5_no_gap", 64'(sil_q.size()), 64'd0);
    check("t5_no_done", 64'(done_cnt), 64'd0);
    check("t5_stay_idle", 64'({busy, audio_silent}), 64'd0);
    audio_finish = 1'b0;

    // Asynchronous reset asserted between clock edges in the middle of a gap.
    fin_auto = 1'b1;
    fin_dly = 10;
    clear_mon();
    exp_codes = '{5'd1};
    push_codes();
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      tick();
      seen = audio_silent;
      n++;
    end
    check("t6_reached_gap", 64'(seen), 64'd1);
    repeat (100) tick();
    #2 reset = 1'b0;
    #1;
    check("t6_async_silent", 64'(audio_silent), 64'd0);
    check("t6_async_busy", 64'(busy), 64'd0);
    check("t6_async_empty", 64'(empty), 64'd1);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("t6_after_release", 64'({busy, empty, done}), 64'b010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
